idex_stage: RTL and testbench
=============================

// Module: idex_stage
// PURPOSE
//  Decode-to-execute pipeline register plus hazard control for the 5-stage RV32I core.
//  - Captures the decoder control bits and the decode-stage datapath values at the D/E boundary.
//  - Detects load-use hazards and taken-branch/jump redirects.
//  - Drives StallF/StallD/FlushD back upstream and inserts bubbles into E.
// PARAMETERS
//  XLEN      32  datapath width (PC, register data, immediate)
//  REGW      5   register index width
//  CNTW      32  perf counter width (used only with IDEX_PERF_CNT_EN)
// PORTS
//  clk          in   1     core clock, rising edge
//  reset_n      in   1     asynchronous active-low reset
//  RegWriteD    in   1     decoder controls (see riscv_pkg::ctrl_t)
//  ResultSrcD   in   2     00 ALU, 01 memory (load), 10 PC+4
//  MemWriteD    in   1
//  JumpD        in   1
//  BranchD      in   1
//  ALUSrcAD     in   1
//  ALUSrcBD     in   2
//  ALUControlD  in   4     from ALU decoder
//  Funct3D      in   3     branch condition select
//  RD1D, RD2D   in   XLEN  register file read data
//  PCD          in   XLEN  PC of the decode-stage instruction
//  PCPlus4D     in   XLEN
//  ImmExtD      in   XLEN
//  Rs1D, Rs2D   in   REGW  source register indices
//  RdD          in   REGW  destination register index
//  PCSrcE       in   1     E-stage redirect (branch taken or jump), computed downstream
//  *E           out  same  registered copies of every *D input above
//  ValidE       out  1     E holds a real instruction (0 = bubble)
//  StallF       out  1     hold the PC register
//  StallD       out  1     hold the IF/ID register
//  FlushD       out  1     clear the IF/ID register to nop
//  StallCnt     out  CNTW  bubbles inserted for load-use (IDEX_PERF_CNT_EN only)
//  FlushCnt     out  CNTW  redirect flushes (IDEX_PERF_CNT_EN only)
// BEHAVIOUR
//  - Latency: 1 cycle. On the rising edge of clk, every *E output takes its *D value unless FlushE is asserted.
//  - FlushE is internal and is not a port. FlushE = lwStall | PCSrcE.
//  - Bubble (FlushE=1): all control outputs go to 0. This gives RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0,
//    ResultSrcE=00, ALUSrcAE=0, ALUSrcBE=00, ALUControlE=0, Funct3E=0, RdE=0, Rs1E=0, Rs2E=0, ValidE=0.
//    Data fields (RD1E, RD2E, PCE, PCPlus4E, ImmExtE) are don't-care and are cleared to 0 for determinism.
//  - Otherwise ValidE=1 after a capture. ValidE is 0 when the captured D instruction was itself a nop.
//  - Reset (reset_n=0, asynchronous, at any time including mid-stall): every *E output, ValidE and the counters
//    clear to 0 immediately. Reset releases cleanly because ResultSrcE=00 after reset, so no stall follows.
//  - Load-use hazard, combinational from current E registers and D inputs:
//    lwStall = (ResultSrcE==2'b01) & (RdE!=0) & ((Rs1D==RdE) | (Rs2D==RdE)).
//  - Outputs: StallF = StallD = lwStall & ~PCSrcE. FlushD = PCSrcE.
//  - Simultaneous lwStall and PCSrcE: the redirect wins. Stalls are 0, FlushD=1, FlushE=1 (the D instruction is
//    wrong-path).
//  - x0 never causes a stall, even when Rs1D or Rs2D equals 0.
//  - A load-use stall lasts exactly 1 cycle: the bubble makes ResultSrcE=00 on the next cycle.
//  - Back-to-back loads into the same register each stall exactly once.
// CONFIGURATION
//  IDEX_PERF_CNT_EN defined:
//   - StallCnt increments on each cycle with lwStall & ~PCSrcE.
//   - FlushCnt increments on each cycle with PCSrcE.
//   - Both counters wrap modulo 2^CNTW and reset to 0.
//  IDEX_PERF_CNT_EN undefined:
//   - StallCnt, FlushCnt and their registers are absent from the port list.
//   - All other behaviour is identical.
// STRUCTURE
//  - riscv_pkg holds:
//    - ctrl_t, a packed struct {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrcA, ALUSrcB[1:0],
//      ALUControl[3:0], Funct3[2:0]};
//    - CTRL_NOP = '0;
//    - RES_MEM = 2'b01;
//    - XLEN and REGW defaults.
//  - Sub-module hazard_detect (pure combinational):
//    - inputs Rs1D, Rs2D, RdE, ResultSrcE, PCSrcE;
//    - outputs StallF, StallD, FlushD, FlushE.
//  - idex_stage holds the registers and the optional counters.
// TESTING
//  1. Reset: assert reset_n=0 mid-cycle with ValidE=1 -> every *E output and ValidE go to 0 before the next edge;
//     StallF=0 after release.
//  2. Load-use: lw x5 in E (ResultSrcE=01, RdE=5) while D has Rs1D=5 -> StallF=StallD=1 for 1 cycle; next E is a
//     bubble (RegWriteE=0, ValidE=0); the following cycle StallF=0 and E captures the add.
//  3. x0 load: lw x0 in E with Rs2D=0 -> no stall; D is captured normally.
//  4. Redirect: PCSrcE=1 with add x1 in D -> FlushD=1; E is a bubble next cycle; StallF=0.
//  5. Collision: lw x7 in E, Rs1D=7 and PCSrcE=1 together -> StallF=StallD=0, FlushD=1, E is a bubble;
//     with IDEX_PERF_CNT_EN, FlushCnt +1 and StallCnt unchanged.
//  6. Counters (IDEX_PERF_CNT_EN, CNTW=4): 17 load-use stalls -> StallCnt wraps to 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RV32I core: decoder control bundle, result-source codes and datapath widths.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [3:0] ALUControl;
        logic [2:0] Funct3;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/idex_stage_hazard_detect.sv
// Load-use and redirect hazard unit; purely combinational, feeds stalls and flushes for the D/E boundary.
module hazard_detect #(
    parameter int REGW = riscv_pkg::REGW
) (
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdE,
    input  logic [1:0]      ResultSrcE,
    input  logic            PCSrcE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE
);
    import riscv_pkg::*;

    logic load_use_s;

    // A load in E whose destination (never x0) is read by the instruction in D
    always_comb begin
        load_use_s = 1'b0;
        if ((ResultSrcE == RES_MEM) && (RdE != {REGW{1'b0}}) &&
            ((Rs1D == RdE) || (Rs2D == RdE))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // A redirect makes the D instruction wrong-path, so it overrides any stall
    assign StallF = load_use_s & ~PCSrcE;
    assign StallD = load_use_s & ~PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = load_use_s | PCSrcE;

endmodule

// File: rtl/idex_stage.sv
// Decode-to-execute pipeline register with hazard control for the 5-stage RV32I core.
// Optional perf counters (StallCnt/FlushCnt) are built only when IDEX_PERF_CNT_EN is defined.
module idex_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcAD,
    input  logic [1:0]      ALUSrcBD,
    input  logic [3:0]      ALUControlD,
    input  logic [2:0]      Funct3D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            PCSrcE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcAE,
    output logic [1:0]      ALUSrcBE,
    output logic [3:0]      ALUControlE,
    output logic [2:0]      Funct3E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic            ValidE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNTW-1:0] StallCnt,
    output logic [CNTW-1:0] FlushCnt
`endif
);
    import riscv_pkg::*;

    ctrl_t           ctrl_d_s;
    logic            valid_d_s;
    logic            flush_e_s;

    ctrl_t           ctrl_r;
    logic [XLEN-1:0] rd1_r;
    logic [XLEN-1:0] rd2_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_plus4_r;
    logic [XLEN-1:0] imm_ext_r;
    logic [REGW-1:0] rs1_r;
    logic [REGW-1:0] rs2_r;
    logic [REGW-1:0] rd_r;
    logic            valid_r;

    assign ctrl_d_s = {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
                       ALUSrcAD, ALUSrcBD, ALUControlD, Funct3D};
    // A decode slot with no control bits set is a nop (that is what FlushD leaves in IF/ID)
    assign valid_d_s = (ctrl_d_s != CTRL_NOP);

    hazard_detect #(
        .REGW (REGW)
    ) u_hazard_detect (
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdE        (rd_r),
        .ResultSrcE (ctrl_r.ResultSrc),
        .PCSrcE     (PCSrcE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (flush_e_s)
    );

    // D/E register: capture decode values, or load a fully cleared bubble on FlushE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r     <= CTRL_NOP;
            rd1_r      <= {XLEN{1'b0}};
            rd2_r      <= {XLEN{1'b0}};
            pc_r       <= {XLEN{1'b0}};
            pc_plus4_r <= {XLEN{1'b0}};
            imm_ext_r  <= {XLEN{1'b0}};
            rs1_r      <= {REGW{1'b0}};
            rs2_r      <= {REGW{1'b0}};
            rd_r       <= {REGW{1'b0}};
            valid_r    <= 1'b0;
        end else if (flush_e_s) begin
            ctrl_r     <= CTRL_NOP;
            rd1_r      <= {XLEN{1'b0}};
            rd2_r      <= {XLEN{1'b0}};
            pc_r       <= {XLEN{1'b0}};
            pc_plus4_r <= {XLEN{1'b0}};
            imm_ext_r  <= {XLEN{1'b0}};
            rs1_r      <= {REGW{1'b0}};
            rs2_r      <= {REGW{1'b0}};
            rd_r       <= {REGW{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            ctrl_r     <= ctrl_d_s;
            rd1_r      <= RD1D;
            rd2_r      <= RD2D;
            pc_r       <= PCD;
            pc_plus4_r <= PCPlus4D;
            imm_ext_r  <= ImmExtD;
            rs1_r      <= Rs1D;
            rs2_r      <= Rs2D;
            rd_r       <= RdD;
            valid_r    <= valid_d_s;
        end
    end

    assign RegWriteE   = ctrl_r.RegWrite;
    assign ResultSrcE  = ctrl_r.ResultSrc;
    assign MemWriteE   = ctrl_r.MemWrite;
    assign JumpE       = ctrl_r.Jump;
    assign BranchE     = ctrl_r.Branch;
    assign ALUSrcAE    = ctrl_r.ALUSrcA;
    assign ALUSrcBE    = ctrl_r.ALUSrcB;
    assign ALUControlE = ctrl_r.ALUControl;
    assign Funct3E     = ctrl_r.Funct3;
    assign RD1E        = rd1_r;
    assign RD2E        = rd2_r;
    assign PCE         = pc_r;
    assign PCPlus4E    = pc_plus4_r;
    assign ImmExtE     = imm_ext_r;
    assign Rs1E        = rs1_r;
    assign Rs2E        = rs2_r;
    assign RdE         = rd_r;
    assign ValidE      = valid_r;

`ifdef IDEX_PERF_CNT_EN
    logic [CNTW-1:0] stall_cnt_r;
    logic [CNTW-1:0] flush_cnt_r;

    // Free-running event counters, wrapping modulo 2^CNTW
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNTW{1'b0}};
            flush_cnt_r <= {CNTW{1'b0}};
        end else begin
            if (StallD) begin
                stall_cnt_r <= stall_cnt_r + CNTW'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (PCSrcE) begin
                flush_cnt_r <= flush_cnt_r + CNTW'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Directed scoreboard bench for idex_stage; counter checks are active when IDEX_PERF_CNT_EN is defined.
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcAD;
    logic [1:0]  ResultSrcD, ALUSrcBD;
    logic [3:0]  ALUControlD;
    logic [2:0]  Funct3D;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        PCSrcE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE;
    logic [1:0]  ResultSrcE, ALUSrcBE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE, StallF, StallD, FlushD;
`ifdef IDEX_PERF_CNT_EN
    logic [3:0]  StallCnt, FlushCnt;
`endif

    int tests = 0;
    int fails = 0;

    // Expected E-stage contents: ctrl(16) rd1 rd2 pc pc4 imm rs1 rs2 rd valid
    logic [191:0] exp_q[$];
    logic [191:0] obs_e;
    logic [1:0]   m_res;
    logic [4:0]   m_rd;
    logic [3:0]   m_scnt, m_fcnt;

    localparam logic [15:0] LW  = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 3'b010};
    localparam logic [15:0] ADD = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000};
    localparam logic [15:0] SW  = {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 3'b010};
    localparam logic [15:0] BEQ = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0001, 3'b000};
    localparam logic [15:0] JAL = {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0000, 3'b000};
    localparam logic [15:0] NOP = 16'h0000;

    always #5 clk = ~clk;

    idex_stage #(.XLEN(32), .REGW(5), .CNTW(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .ALUControlD(ALUControlD),
        .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ALUControlE(ALUControlE),
        .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
`ifdef IDEX_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    assign obs_e = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, ALUControlE,
                    Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE};

    task automatic check(input string tag, input logic [191:0] o, input logic [191:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One decode slot, entered and left at a falling edge
    task automatic step(input string tag, input logic [15:0] ctrl, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic pcsrc);
        logic [31:0] base;
        logic        lw, stall;
        logic [191:0] e;
        base = $urandom;
        {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcAD, ALUSrcBD, ALUControlD, Funct3D} = ctrl;
        RD1D = base; RD2D = base ^ 32'h5a5a_5a5a; PCD = {base[31:2], 2'b00};
        PCPlus4D = {base[31:2], 2'b00} + 32'd4; ImmExtD = ~base;
        Rs1D = rs1; Rs2D = rs2; RdD = rd; PCSrcE = pcsrc;
        #1;
        lw    = (m_res == 2'b01) && (m_rd != 5'd0) && ((rs1 == m_rd) || (rs2 == m_rd));
        stall = lw && !pcsrc;
        check({tag, " StallF"}, {191'd0, StallF}, {191'd0, stall});
        check({tag, " StallD"}, {191'd0, StallD}, {191'd0, stall});
        check({tag, " FlushD"}, {191'd0, FlushD}, {191'd0, pcsrc});
        if (lw || pcsrc) exp_q.push_back(192'd0);
        else exp_q.push_back({ctrl, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, rs1, rs2, rd, (ctrl != 16'h0000)});
        if (stall) m_scnt = m_scnt + 4'd1;
        if (pcsrc) m_fcnt = m_fcnt + 4'd1;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " E"}, obs_e, e);
        m_res = e[190:189];
        m_rd  = e[5:1];
`ifdef IDEX_PERF_CNT_EN
        check({tag, " StallCnt"}, {188'd0, StallCnt}, {188'd0, m_scnt});
        check({tag, " FlushCnt"}, {188'd0, FlushCnt}, {188'd0, m_fcnt});
`endif
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_res = 2'b00; m_rd = 5'd0; m_scnt = 4'd0; m_fcnt = 4'd0;
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcAD, ALUSrcBD, ALUControlD, Funct3D} = 16'h0000;
        RD1D = 32'd0; RD2D = 32'd0; PCD = 32'd0; PCPlus4D = 32'd0; ImmExtD = 32'd0;
        Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; PCSrcE = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset E", obs_e, 192'd0);
        reset_n = 1'b1;

        // Mid-cycle asynchronous reset while E holds a valid instruction
        step("pre-reset add", ADD, 5'd2, 5'd3, 5'd4, 1'b0);
        #2 reset_n = 1'b0;
        #1 check("async reset E", obs_e, 192'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step("post-reset add", ADD, 5'd0, 5'd0, 5'd0, 1'b0);

        // Load-use on rs1: one stall, bubble, then the add goes through
        step("lw x5", LW, 5'd1, 5'd0, 5'd5, 1'b0);
        step("add stall", ADD, 5'd5, 5'd6, 5'd8, 1'b0);
        step("add retry", ADD, 5'd5, 5'd6, 5'd8, 1'b0);

        // Load-use on rs2 through a store
        step("lw x12", LW, 5'd1, 5'd0, 5'd12, 1'b0);
        step("sw stall", SW, 5'd2, 5'd12, 5'd0, 1'b0);
        step("sw retry", SW, 5'd2, 5'd12, 5'd0, 1'b0);

        // Load into x0 never stalls
        step("lw x0", LW, 5'd1, 5'd0, 5'd0, 1'b0);
        step("add x0 src", ADD, 5'd0, 5'd0, 5'd9, 1'b0);

        // Redirect flushes D
        step("beq", BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        step("redirect add", ADD, 5'd1, 5'd2, 5'd1, 1'b1);

        // Load-use and redirect in the same cycle
        step("lw x7", LW, 5'd1, 5'd0, 5'd7, 1'b0);
        step("collision", ADD, 5'd7, 5'd3, 5'd2, 1'b1);

        // Back-to-back loads into one register, each stalls once
        step("lw x3 a", LW, 5'd1, 5'd0, 5'd3, 1'b0);
        step("lw x3 b stall", LW, 5'd3, 5'd0, 5'd3, 1'b0);
        step("lw x3 b", LW, 5'd3, 5'd0, 5'd3, 1'b0);
        step("use x3 stall", ADD, 5'd4, 5'd3, 5'd10, 1'b0);
        step("use x3", ADD, 5'd4, 5'd3, 5'd10, 1'b0);

        // Non-load producer does not stall; nop captures with ValidE=0
        step("jal", JAL, 5'd0, 5'd0, 5'd1, 1'b0);
        step("after jal", ADD, 5'd1, 5'd1, 5'd11, 1'b0);
        step("nop", NOP, 5'd0, 5'd0, 5'd0, 1'b0);

        // Counter wrap: 17 load-use stalls from a clean reset
        reset_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step("wrap lw", LW, 5'd1, 5'd0, 5'd9, 1'b0);
            step("wrap use", ADD, 5'd9, 5'd2, 5'd13, 1'b0);
        end
`ifdef IDEX_PERF_CNT_EN
        check("StallCnt wrap", {188'd0, StallCnt}, {188'd0, 4'd1});
        check("FlushCnt idle", {188'd0, FlushCnt}, 192'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
